rst_sync_seq: RTL and testbench



---
 rtl/rst_sync_seq.sv | 132 +++++++++++++
 tb/tb_rst_sync_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rst_sync_seq.sv
// Reset sequencer for the router core. Reset asserts asynchronously and is released
// through a synchroniser and a hold stretch. It also runs software-requested reset sequences.
module rst_sync_seq #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned SW_RST_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       ARST,
  input  logic       SW_RST_REQ,
  output logic       SRST,
  output logic       SRSTn,
  output logic       READY,
  output logic       SW_RST_ACK,
  output logic [7:0] RST_EVENTS
);

  // The state flop leaving ST_ARST acts as the final synchroniser stage.
  localparam int unsigned CHAIN_W = (SYNC_STAGES > 1) ? SYNC_STAGES - 1 : 1;
  localparam int unsigned MAX_CYC = (HOLD_CYCLES > SW_RST_CYCLES) ? HOLD_CYCLES : SW_RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_RST_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rst_sync_seq: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_sync_seq: HOLD_CYCLES must be >= 1");
  end
  if (SW_RST_CYCLES < 1) begin : g_bad_sw
    $error("rst_sync_seq: SW_RST_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_ARST  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_SWRST = 2'd3
  } state_e;

  state_e             state_q,  state_d;
  logic [CHAIN_W-1:0] sync_q,   sync_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               srst_q,   srst_d;
  logic               srstn_q,  srstn_d;
  logic               ready_q,  ready_d;
  logic               ack_q,    ack_d;
  logic [7:0]         events_q, events_d;

  // Next-state and registered-output logic.
  always_comb begin
    sync_d   = sync_q << 1;
    state_d  = state_q;
    cnt_d    = cnt_q;
    srst_d   = srst_q;
    srstn_d  = srstn_q;
    ready_d  = ready_q;
    ack_d    = 1'b0;
    events_d = events_q;

    case (state_q)
      ST_ARST: begin
        if (!sync_q[CHAIN_W-1]) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          srst_d  = 1'b0;
          srstn_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (ready_q && SW_RST_REQ) begin
          state_d  = ST_SWRST;
          cnt_d    = '0;
          srst_d   = 1'b1;
          srstn_d  = 1'b0;
          ready_d  = 1'b0;
          ack_d    = 1'b1;
          events_d = (events_q == 8'hFF) ? events_q : events_q + 8'd1;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_SWRST: begin
        if (cnt_q == SW_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_ARST;
    endcase
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      sync_q   <= '1;
      state_q  <= ST_ARST;
      cnt_q    <= '0;
      srst_q   <= 1'b1;
      srstn_q  <= 1'b0;
      ready_q  <= 1'b0;
      ack_q    <= 1'b0;
      events_q <= 8'd0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      srst_q   <= srst_d;
      srstn_q  <= srstn_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
      events_q <= events_d;
    end
  end

  assign SRST       = srst_q;
  assign SRSTn      = srstn_q;
  assign READY      = ready_q;
  assign SW_RST_ACK = ack_q;
  assign RST_EVENTS = events_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Randomised scoreboard bench for rst_sync_seq: the stimulus side predicts edge-numbered
// output events from the sequence timing rules, and a monitor matches them against the DUT.
module tb_rst_sync_seq;

  localparam int S   = 2;
  localparam int H   = 16;
  localparam int W   = 4;
  localparam int INF = 1 << 30;

  localparam int EV_ACK  = 0;
  localparam int EV_FALL = 1;
  localparam int EV_RISE = 2;

  typedef struct {
    int kind;
    int cyc;
    int events;
  } exp_t;

  logic       CLK = 1'b0;
  logic       ARST = 1'b0;
  logic       SW_RST_REQ = 1'b0;
  logic       SRST, SRSTn, READY, SW_RST_ACK;
  logic [7:0] RST_EVENTS;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ack_seen = 0;
  int   model_events = 0;
  int   ready_at = INF;
  bit   clk_en = 1'b0;

  rst_sync_seq #(.SYNC_STAGES(S), .HOLD_CYCLES(H), .SW_RST_CYCLES(W)) dut (
    .CLK(CLK), .ARST(ARST), .SW_RST_REQ(SW_RST_REQ),
    .SRST(SRST), .SRSTn(SRSTn), .READY(READY),
    .SW_RST_ACK(SW_RST_ACK), .RST_EVENTS(RST_EVENTS)
  );

  initial begin
    wait (clk_en);
    forever #5 CLK = ~CLK;
  end

  // Edge number: value after the n-th posedge is n.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int kind, input int c, input int ev);
    exp_t e;
    e.kind = kind;
    e.cyc = c;
    e.events = ev;
    return e;
  endfunction

  // ARST has just fallen with the next posedge being edge 1.
  task automatic model_release();
    int c;
    c = cyc;
    sb.push_back(mk(EV_FALL, c + S + H, model_events));
    sb.push_back(mk(EV_RISE, c + S + H + 1, model_events));
    ready_at = c + S + H + 1;
  endtask

  task automatic arst_on();
    SW_RST_REQ = 1'b0;
    ARST = 1'b1;
    sb.delete();
    model_events = 0;
    ready_at = INF;
    #1;
    chk("arst_srst", int'(SRST), 1);
    chk("arst_srstn", int'(SRSTn), 0);
    chk("arst_ready", int'(READY), 0);
    chk("arst_ack", int'(SW_RST_ACK), 0);
    chk("arst_events", int'(RST_EVENTS), 0);
  endtask

  task automatic arst_cycle(input int hold);
    @(negedge CLK);
    arst_on();
    repeat (hold) @(negedge CLK);
    ARST = 1'b0;
    model_release();
  endtask

  // Drive one cycle; the request is accepted only once READY was already high before the edge.
  task automatic step(input logic req);
    int e;
    @(negedge CLK);
    SW_RST_REQ = req;
    e = cyc + 1;
    if (req && e >= ready_at + 1) begin
      model_events = (model_events >= 255) ? 255 : model_events + 1;
      sb.push_back(mk(EV_ACK, e, model_events));
      sb.push_back(mk(EV_FALL, e + W + H, model_events));
      sb.push_back(mk(EV_RISE, e + W + H + 1, model_events));
      ready_at = e + W + H + 1;
    end
  endtask

  task automatic run(input int n, input int pct);
    for (int i = 0; i < n; i++) step($urandom_range(0, 99) < pct);
  endtask

  task automatic drop_missed();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missed_event: kind=%0d due at edge %0d, not observed by edge %0d", e.kind, e.cyc, cyc);
    end
  endtask

  task automatic match_ev(input int kind);
    exp_t e;
    drop_missed();
    if (sb.size() == 0 || sb[0].cyc != cyc || sb[0].kind != kind) begin
      total++;
      bad++;
      if (sb.size() == 0)
        $display("FAIL unexpected_event: kind=%0d at edge %0d, none expected", kind, cyc);
      else
        $display("FAIL unexpected_event: kind=%0d at edge %0d, expected kind=%0d at edge %0d",
                 kind, cyc, sb[0].kind, sb[0].cyc);
    end else begin
      e = sb.pop_front();
      chk("event_count", int'(RST_EVENTS), e.events);
    end
  endtask

  // Monitor: sample after each edge, detect output events and pop the scoreboard.
  initial begin
    logic prev_srst, prev_ready;
    prev_srst = 1'b1;
    prev_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      chk("srstn_inv", int'(SRSTn), int'(!SRST));
      if (SW_RST_ACK) begin
        ack_seen++;
        match_ev(EV_ACK);
      end
      if (prev_srst && !SRST) match_ev(EV_FALL);
      if (!prev_ready && READY) match_ev(EV_RISE);
      drop_missed();
      prev_srst = SRST;
      prev_ready = READY;
    end
  end

  initial begin
    int ack_base;
    // Reset with the clock stopped.
    #1;
    arst_on();
    #3;
    ARST = 1'b0;
    model_release();
    clk_en = 1'b1;
    run(22, 0);

    // Single software reset pulse.
    step(1'b1);
    run(30, 0);

    // Request held high for 100 cycles after READY.
    ack_base = ack_seen;
    run(100, 100);
    chk("held_ack_count", ack_seen - ack_base, 5);
    run(25, 0);

    // ARST during hold, then during the software-reset phase.
    arst_cycle(2);
    run(9, 0);
    arst_cycle(2);
    run(25, 0);
    step(1'b1);
    run(2, 0);
    arst_cycle(2);
    run(25, 0);

    // Sub-cycle ARST pulse between edges, with requests during the sequence.
    @(posedge CLK);
    #2;
    arst_on();
    #2;
    ARST = 1'b0;
    model_release();
    run(15, 100);
    run(10, 0);

    // Random requests with occasional ARST.
    for (int r = 0; r < 6; r++) begin
      run($urandom_range(30, 90), 30);
      if ($urandom_range(0, 1) == 1) arst_cycle($urandom_range(1, 3));
    end
    run(25, 0);

    // Saturation of the event counter, then clear by ARST.
    run(260 * (W + H + 2) + 30, 100);
    run(25, 0);
    chk("events_saturated", int'(RST_EVENTS), 255);
    arst_cycle(2);
    run(25, 0);
    chk("events_cleared", int'(RST_EVENTS), 0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
